// File: rtl/dl_pipe.sv
// Elastic multi-stage pipeline register with valid/ready handshake, synchronous flush
// and a registered occupancy count. Bubbles collapse toward the output side.
module dl_pipe #(
  parameter int              WIDTH   = 32,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stageData_q [DEPTH];
  logic [WIDTH-1:0] stageData_d [DEPTH];
  logic [DEPTH-1:0] stageValid_q;
  logic [DEPTH-1:0] stageValid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] advance;
  logic             chainFull;
  logic             inXfer;
  logic             outXfer;

  // A stage may load when everything from it to the output is full only if the
  // output is draining; any empty slot downstream lets it move.
  always_comb begin
    advance   = '0;
    chainFull = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chainFull  = chainFull & stageValid_q[i];
      advance[i] = out_ready | ~chainFull;
    end
  end

  assign in_ready  = advance[0] & ~flush;
  assign inXfer    = in_valid & in_ready;
  assign outXfer   = stageValid_q[DEPTH-1] & out_ready & ~flush;
  assign out_valid = stageValid_q[DEPTH-1];
  assign dout      = stageData_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    stageValid_d = stageValid_q;
    stageData_d  = stageData_q;
    if (flush) begin
      stageValid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        stageData_d[i] = RST_VAL;
      end
    end else begin
      if (advance[0]) begin
        stageValid_d[0] = in_valid;
        if (in_valid) begin
          stageData_d[0] = din;
        end
      end
      // Data only moves with a valid word so bubbles never overwrite held values.
      for (int i = 1; i < DEPTH; i++) begin
        if (advance[i]) begin
          stageValid_d[i] = stageValid_q[i-1];
          if (stageValid_q[i-1]) begin
            stageData_d[i] = stageData_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (inXfer && !outXfer) begin
      count_d = count_q + CW'(1);
    end else if (outXfer && !inXfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stageValid_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stageData_q[i] <= RST_VAL;
      end
    end else begin
      stageValid_q <= stageValid_d;
      count_q      <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        stageData_q[i] <= stageData_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dl_pipe.sv
// Directed self-checking bench for dl_pipe using three instances (DEPTH 2, 3, 4)
// sharing one clock and reset, each exercised by its own directed sequence.
module tb_dl_pipe;

  localparam logic [31:0] RST2 = 32'hDEADBEEF;
  localparam logic [31:0] RST3 = 32'h0000_0000;
  localparam logic [31:0] RST4 = 32'h5A5A_0000;

  logic        clk;
  logic        rst;

  logic        fl2, iv2, ir2, ov2, or2;
  logic [31:0] din2, dout2;
  logic [1:0]  cnt2;

  logic        fl3, iv3, ir3, ov3, or3;
  logic [31:0] din3, dout3;
  logic [1:0]  cnt3;

  logic        fl4, iv4, ir4, ov4, or4;
  logic [31:0] din4, dout4;
  logic [2:0]  cnt4;

  int errorCount;
  int checkCount;
  int expCnt3 [7] = '{1, 2, 3, 3, 2, 1, 0};

  dl_pipe #(.WIDTH(32), .DEPTH(2), .RST_VAL(RST2)) u2 (
    .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2), .din(din2),
    .out_valid(ov2), .out_ready(or2), .dout(dout2), .count(cnt2)
  );

  dl_pipe #(.WIDTH(32), .DEPTH(3), .RST_VAL(RST3)) u3 (
    .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3), .din(din3),
    .out_valid(ov3), .out_ready(or3), .dout(dout3), .count(cnt3)
  );

  dl_pipe #(.WIDTH(32), .DEPTH(4), .RST_VAL(RST4)) u4 (
    .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(ir4), .din(din4),
    .out_valid(ov4), .out_ready(or4), .dout(dout4), .count(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    assert (got === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    fl2 = 0; iv2 = 0; or2 = 0; din2 = '0;
    fl3 = 0; iv3 = 0; or3 = 0; din3 = '0;
    fl4 = 0; iv4 = 0; or4 = 0; din4 = '0;

    // Reset asserted away from any edge must take effect immediately.
    #1 rst = 1'b0;
    #10;
    checkOutput("rst_dout2", dout2, RST2);
    checkOutput("rst_ov2", ov2, 1'b0);
    checkOutput("rst_cnt2", cnt2, 2'd0);
    checkOutput("rst_ir2", ir2, 1'b1);
    checkOutput("rst_dout4", dout4, RST4);

    #1 rst = 1'b1;
    iv2 = 1'b1; din2 = 32'h0000_1234;
    stepClock();
    checkOutput("first_accept_cnt2", cnt2, 2'd1);
    iv2 = 1'b0;
    stepClock();
    checkOutput("held_ov2", ov2, 1'b1);
    checkOutput("held_dout2", dout2, 32'h0000_1234);

    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_dout2", dout2, RST2);
    checkOutput("async_rst_ov2", ov2, 1'b0);
    checkOutput("async_rst_cnt2", cnt2, 2'd0);
    checkOutput("async_rst_ir2", ir2, 1'b1);
    #2 rst = 1'b1;

    // Streaming through DEPTH=3 with out_ready held high.
    or3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      iv3  = (k < 4);
      din3 = 32'(k + 1);
      stepClock();
      checkOutput("stream_cnt3", cnt3, 64'(expCnt3[k]));
      checkOutput("stream_ov3", ov3, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) checkOutput("stream_dout3", dout3, 64'(k - 1));
    end
    iv3 = 1'b0; or3 = 1'b0;

    // Backpressure on DEPTH=2: third word waits until the output drains.
    iv2 = 1'b1; din2 = 32'd10;
    stepClock();
    checkOutput("bp_cnt_1", cnt2, 2'd1);
    checkOutput("bp_ir_1", ir2, 1'b1);
    din2 = 32'd11;
    stepClock();
    checkOutput("bp_cnt_full", cnt2, 2'd2);
    checkOutput("bp_ov_full", ov2, 1'b1);
    checkOutput("bp_dout_10", dout2, 32'd10);
    checkOutput("bp_ir_full", ir2, 1'b0);
    din2 = 32'd12;
    stepClock();
    checkOutput("bp_cnt_hold", cnt2, 2'd2);
    checkOutput("bp_dout_hold", dout2, 32'd10);
    checkOutput("bp_ir_hold", ir2, 1'b0);
    or2 = 1'b1;
    #1;
    checkOutput("bp_ir_drain", ir2, 1'b1);
    stepClock();
    checkOutput("bp_dout_11", dout2, 32'd11);
    checkOutput("bp_cnt_swap", cnt2, 2'd2);
    iv2 = 1'b0;
    stepClock();
    checkOutput("bp_dout_12", dout2, 32'd12);
    checkOutput("bp_cnt_drain1", cnt2, 2'd1);
    stepClock();
    checkOutput("bp_ov_empty", ov2, 1'b0);
    checkOutput("bp_cnt_empty", cnt2, 2'd0);
    or2 = 1'b0;

    // Full pipe consumes and accepts in the same cycle.
    iv2 = 1'b1; din2 = 32'd5;
    stepClock();
    din2 = 32'd6;
    stepClock();
    checkOutput("sim_cnt_full", cnt2, 2'd2);
    checkOutput("sim_dout_5", dout2, 32'd5);
    checkOutput("sim_ir_full", ir2, 1'b0);
    or2 = 1'b1; din2 = 32'd7;
    #1;
    checkOutput("sim_ir_ready", ir2, 1'b1);
    stepClock();
    checkOutput("sim_cnt_same", cnt2, 2'd2);
    checkOutput("sim_dout_6", dout2, 32'd6);
    iv2 = 1'b0;
    stepClock();
    checkOutput("sim_dout_7", dout2, 32'd7);
    checkOutput("sim_cnt_1", cnt2, 2'd1);
    stepClock();
    checkOutput("sim_cnt_0", cnt2, 2'd0);
    or2 = 1'b0;

    // Flush on DEPTH=4 discards held words and the word offered alongside it.
    iv4 = 1'b1; din4 = 32'd21;
    stepClock();
    din4 = 32'd22;
    stepClock();
    din4 = 32'd23;
    stepClock();
    iv4 = 1'b0;
    stepClock();
    checkOutput("fl_cnt_pre", cnt4, 3'd3);
    checkOutput("fl_ov_pre", ov4, 1'b1);
    checkOutput("fl_dout_pre", dout4, 32'd21);
    fl4 = 1'b1; iv4 = 1'b1; din4 = 32'd9;
    #1;
    checkOutput("fl_ir_forced", ir4, 1'b0);
    stepClock();
    checkOutput("fl_cnt_post", cnt4, 3'd0);
    checkOutput("fl_ov_post", ov4, 1'b0);
    checkOutput("fl_dout_post", dout4, RST4);
    fl4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
    #1;
    checkOutput("fl_ir_after", ir4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      stepClock();
      checkOutput("fl_no_nine", ov4, 1'b0);
    end
    or4 = 1'b0;

    // A lone word slides to the last stage even with out_ready low.
    iv3 = 1'b1; din3 = 32'h0000_000A;
    stepClock();
    checkOutput("bub_cnt_acc", cnt3, 2'd1);
    checkOutput("bub_ov_acc", ov3, 1'b0);
    iv3 = 1'b0;
    stepClock();
    checkOutput("bub_ov_mid", ov3, 1'b0);
    stepClock();
    checkOutput("bub_ov_last", ov3, 1'b1);
    checkOutput("bub_dout_last", dout3, 32'h0000_000A);
    checkOutput("bub_cnt_last", cnt3, 2'd1);
    stepClock();
    checkOutput("bub_dout_hold", dout3, 32'h0000_000A);
    checkOutput("bub_ov_hold", ov3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
